// File: rtl/execute_stage_if.sv
// Execute-stage bundle interface.
// Carries the decode-side instruction bundle into the execute stage and the
// registered execute results (plus the busy indication) back out.
//   master : decode/upstream side (drives *_D bundle, observes *_E results)
//   slave  : execute_stage (consumes *_D bundle, drives *_E results)
interface execute_stage_if;
  logic        valid_D;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        use_imm;
  logic [3:0]  alu_op;
  logic        reg_WE_D;
  logic [4:0]  rd_D;
  logic [31:0] pc_D;

  logic        valid_E;
  logic [31:0] alu_result;
  logic [4:0]  rd_E;
  logic        reg_WE_E;
  logic [31:0] pc_E;
  logic        busy_E;

  modport master (
    output valid_D, rs1_val, rs2_val, imm, use_imm, alu_op, reg_WE_D, rd_D, pc_D,
    input  valid_E, alu_result, rd_E, reg_WE_E, pc_E, busy_E
  );

  modport slave (
    input  valid_D, rs1_val, rs2_val, imm, use_imm, alu_op, reg_WE_D, rd_D, pc_D,
    output valid_E, alu_result, rd_E, reg_WE_E, pc_E, busy_E
  );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the integer pipeline.
// Single-cycle ALU for ADD/SUB/logic/shift/compare ops; MUL runs as a
// radix-2 shift-add iteration over MUL_CYCLES edges while busy_E is high.
// Ports:
//   clk      pipeline clock
//   reset_E  asynchronous active-high reset
//   stall_E  hold the stage register (ignored while multiplying)
//   flush_E  insert a bubble; aborts an in-flight multiply
//   bus      execute_stage_if.slave: decode bundle in, registered results out
module execute_stage #(
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_E,
  input  logic stall_E,
  input  logic flush_E,
  execute_stage_if.slave bus
);

  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {IDLE, MUL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              we_q, we_d;
  logic [31:0]       res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       pc_q, pc_d;

  logic [31:0]       mcand_q, mcand_d;
  logic [31:0]       mplier_q, mplier_d;
  logic [31:0]       acc_q, acc_d;
  logic              wel_q, wel_d;

  logic [31:0]       opb;
  logic [31:0]       acc_step;

  assign opb = bus.use_imm ? bus.imm : bus.rs2_val;

  function automatic logic [31:0] alu_fn(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [4:0]         sh;
    logic [31:0]        r;
    a_s = signed'(a);
    b_s = signed'(b);
    sh  = b[4:0];
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << sh;
      4'd6:    r = a >> sh;
      4'd7:    r = unsigned'(a_s >>> sh);
      4'd8:    r = {31'd0, (a_s < b_s)};
      4'd9:    r = {31'd0, (a < b)};
      // MUL is produced by the iterative path; a bubble MUL latches 0
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    we_d     = we_q;
    res_d    = res_q;
    rd_d     = rd_q;
    pc_d     = pc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    wel_d    = wel_q;
    acc_step = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    case (state_q)
      IDLE: begin
        if (flush_E) begin
          valid_d = 1'b0;
          we_d    = 1'b0;
        end else if (!stall_E) begin
          rd_d = bus.rd_D;
          pc_d = bus.pc_D;
          if (bus.valid_D && (bus.alu_op == OP_MUL)) begin
            // Result stays invisible to the memory stage until the product is done
            state_d  = MUL;
            cnt_d    = '0;
            valid_d  = 1'b0;
            we_d     = 1'b0;
            wel_d    = bus.reg_WE_D;
            mcand_d  = bus.rs1_val;
            mplier_d = opb;
            acc_d    = '0;
          end else begin
            res_d   = alu_fn(bus.alu_op, bus.rs1_val, opb);
            valid_d = bus.valid_D;
            we_d    = bus.valid_D & bus.reg_WE_D;
          end
        end
      end
      MUL: begin
        if (flush_E) begin
          state_d = IDLE;
          cnt_d   = '0;
          valid_d = 1'b0;
          we_d    = 1'b0;
        end else begin
          // stall_E deliberately ignored so the iteration count always advances
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = acc_step;
            valid_d = 1'b1;
            we_d    = wel_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_E) begin
    if (reset_E) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      we_q    <= we_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
    end
  end

  // Multiply working registers are always reloaded at capture, so no reset
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    wel_q    <= wel_d;
  end

  assign bus.valid_E    = valid_q;
  assign bus.alu_result = res_q;
  assign bus.rd_E       = rd_q;
  assign bus.reg_WE_E   = we_q;
  assign bus.pc_E       = pc_q;
  assign bus.busy_E     = (state_q == MUL);

endmodule
